program_loader: RTL and testbench

Host-side feeder for the pipelined CPU's instruction-load port. It is the transmitter that drives LoadInstructions, Instruction and the CPU reset.
It receives a program as a byte stream over a valid/ready handshake and assembles big-endian 32-bit words into an internal buffer. It then streams the words into instruction memory on consecutive cycles and restarts the CPU so that PC begins at 0.
It sits between the bench or host link and the CPU top level.

---
 rtl/program_loader.sv | 141 ++++++++++++++
 tb/tb_program_loader.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/program_loader.sv
// Host-side program loader: collects a big-endian byte stream into a word buffer,
// streams it into CPU instruction memory on back-to-back cycles, then restarts the CPU.
module program_loader #(
  parameter int WORD_COUNT = 32,
  parameter int CNT_W      = 6
) (
  input  logic             clk,
  input  logic             Reset,
  input  logic             start,
  input  logic [CNT_W-1:0] len,
  input  logic [7:0]       byte_in,
  input  logic             byte_valid,
  output logic             byte_ready,
  output logic [31:0]      Instruction,
  output logic             LoadInstructions,
  output logic             cpu_reset,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [CNT_W-1:0] words_loaded
);

  localparam int AW = (WORD_COUNT > 1) ? $clog2(WORD_COUNT) : 1;

  typedef enum logic [2:0] {
    IDLE, HOLD, COLLECT, RELEASE, STREAM, RESTART, RUN
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] n_q;        // latched program length
  logic [CNT_W-1:0] wcnt;       // words collected
  logic [CNT_W-1:0] idx;        // stream index
  logic [1:0]       bcnt;       // byte position within current word
  logic [23:0]      asm_q;      // first three bytes of the word in flight
  logic             first_run;
  logic [31:0]      mem [WORD_COUNT];

  logic len_ok, start_ok, take, word_done, last_word, last_idx;

  assign len_ok    = (len != '0) && (len <= CNT_W'(WORD_COUNT));
  assign start_ok  = start && len_ok && (state == IDLE || state == RUN);
  assign take      = byte_ready && byte_valid;
  assign word_done = take && (bcnt == 2'd3);
  assign last_word = word_done && (wcnt == n_q - 1'b1);
  assign last_idx  = (idx == n_q - 1'b1);

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt        = state;
    byte_ready       = 1'b0;
    LoadInstructions = 1'b0;
    cpu_reset        = 1'b1;
    busy             = 1'b0;
    done             = 1'b0;
    err              = 1'b0;
    Instruction      = '0;
    case (state)
      IDLE: begin
        if (start) begin
          if (len_ok) state_nxt = HOLD;
          else        err       = 1'b1;
        end
      end
      HOLD: begin
        busy      = 1'b1;
        state_nxt = COLLECT;
      end
      COLLECT: begin
        busy       = 1'b1;
        byte_ready = 1'b1;
        if (last_word) state_nxt = RELEASE;
      end
      RELEASE: begin
        busy      = 1'b1;
        state_nxt = STREAM;
      end
      STREAM: begin
        busy             = 1'b1;
        cpu_reset        = 1'b0;
        LoadInstructions = 1'b1;
        Instruction      = mem[idx[AW-1:0]];
        if (last_idx) state_nxt = RESTART;
      end
      RESTART: begin
        busy      = 1'b1;
        state_nxt = RUN;
      end
      RUN: begin
        cpu_reset = 1'b0;
        done      = first_run;
        // a valid start here begins a reload; the CPU goes back into reset in HOLD
        if (start) begin
          if (len_ok) state_nxt = HOLD;
          else        err       = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      n_q          <= '0;
      wcnt         <= '0;
      idx          <= '0;
      bcnt         <= '0;
      asm_q        <= '0;
      words_loaded <= '0;
      first_run    <= 1'b0;
    end else begin
      first_run <= (state == RESTART);
      if (start_ok) begin
        n_q  <= len;
        wcnt <= '0;
        bcnt <= '0;
      end
      if (state == COLLECT && take) begin
        if (bcnt == 2'd3) begin
          bcnt <= '0;
          wcnt <= wcnt + 1'b1;
        end else begin
          asm_q <= {asm_q[15:0], byte_in};
          bcnt  <= bcnt + 1'b1;
        end
      end
      if (state == RELEASE) idx <= '0;
      if (state == STREAM)  idx <= idx + 1'b1;
      if (state == RESTART) words_loaded <= n_q;
    end
  end

  // buffer is storage only; reset leaves contents untouched
  always_ff @(posedge clk) begin
    if (state == COLLECT && word_done) mem[wcnt[AW-1:0]] <= {asm_q, byte_in};
  end

endmodule

// File: tb/tb_program_loader.sv
// Randomized self-checking bench for program_loader against a cycle-timeline reference model.
module tb_program_loader;
  localparam int WC = 32;
  localparam int CW = 6;

  logic          clk = 1'b0;
  logic          Reset = 1'b0;
  logic          start = 1'b0;
  logic [CW-1:0] len = '0;
  logic [7:0]    byte_in = '0;
  logic          byte_valid = 1'b0;
  logic          byte_ready;
  logic [31:0]   Instruction;
  logic          LoadInstructions;
  logic          cpu_reset;
  logic          busy;
  logic          done;
  logic          err;
  logic [CW-1:0] words_loaded;

  int         nvec = 0;
  int         nerr = 0;
  logic [7:0] src[$];

  program_loader #(.WORD_COUNT(WC), .CNT_W(CW)) dut (
    .clk(clk), .Reset(Reset), .start(start), .len(len),
    .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(byte_ready),
    .Instruction(Instruction), .LoadInstructions(LoadInstructions),
    .cpu_reset(cpu_reset), .busy(busy), .done(done), .err(err),
    .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    nvec++;
    if (obs !== expv) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h", tag, obs, expv);
    end
  endtask

  task automatic reject(input int l, input bit in_run);
    @(negedge clk); start = 1'b1; len = CW'(l); #1;
    chk("rej_err", 32'(err), 1);
    chk("rej_busy", 32'(busy), 0);
    @(negedge clk); start = 1'b0; #1;
    chk("rej_err_clr", 32'(err), 0);
    chk("rej_crst", 32'(cpu_reset), in_run ? 0 : 1);
    chk("rej_rdy", 32'(byte_ready), 0);
    chk("rej_busy2", 32'(busy), 0);
  endtask

  // mode: 0 back-to-back, 1 valid every other cycle, 2 random gaps + ignored starts
  task automatic load(input int n, input int mode, input int abort_at);
    logic [7:0]  bytes[$];
    logic [31:0] words[$];
    logic [31:0] wd;
    logic [7:0]  b;
    int got, cyc, pct;
    for (int w = 0; w < n; w++) begin
      wd = 0;
      for (int k = 0; k < 4; k++) begin
        b = (src.size() > 0) ? src.pop_front() : 8'($urandom);
        bytes.push_back(b);
        wd = (wd << 8) | 32'(b);
      end
      words.push_back(wd);
    end
    pct = $urandom_range(0, 70);

    @(negedge clk); start = 1'b1; len = CW'(n); #1;
    chk("acc_err", 32'(err), 0);
    @(negedge clk); start = 1'b0; #1;
    chk("hold_crst", 32'(cpu_reset), 1);
    chk("hold_rdy", 32'(byte_ready), 0);
    chk("hold_busy", 32'(busy), 1);
    chk("hold_li", 32'(LoadInstructions), 0);

    got = 0; cyc = 0;
    while (got < 4 * n) begin
      @(negedge clk);
      case (mode)
        0:       byte_valid = 1'b1;
        1:       byte_valid = (cyc % 2 == 0);
        default: byte_valid = ($urandom_range(0, 99) >= pct);
      endcase
      byte_in = bytes[got];
      if (mode == 2 && $urandom_range(0, 9) == 0) begin start = 1'b1; len = 1; end
      else start = 1'b0;
      #1;
      chk("col_rdy", 32'(byte_ready), 1);
      if (start) chk("col_start_err", 32'(err), 0);
      if (byte_valid && byte_ready) got++;
      cyc++;
      if (cyc > 4000) begin
        chk("col_timeout", got, 4 * n);
        return;
      end
    end

    // valid kept high with junk: no fifth byte may be taken
    @(negedge clk); start = 1'b0; byte_valid = 1'b1; byte_in = 8'hEE; #1;
    chk("rel_rdy", 32'(byte_ready), 0);
    chk("rel_li", 32'(LoadInstructions), 0);
    chk("rel_crst", 32'(cpu_reset), 1);
    chk("rel_busy", 32'(busy), 1);

    for (int i = 0; i < n; i++) begin
      @(negedge clk); byte_valid = 1'b0; #1;
      if (i == abort_at) begin
        Reset = 1'b0; #1;
        chk("rst_li", 32'(LoadInstructions), 0);
        chk("rst_crst", 32'(cpu_reset), 1);
        chk("rst_busy", 32'(busy), 0);
        @(negedge clk); Reset = 1'b1;
        @(negedge clk); #1;
        chk("rst_idle_busy", 32'(busy), 0);
        chk("rst_idle_crst", 32'(cpu_reset), 1);
        chk("rst_idle_li", 32'(LoadInstructions), 0);
        chk("rst_idle_rdy", 32'(byte_ready), 0);
        chk("rst_idle_wl", 32'(words_loaded), 0);
        return;
      end
      chk("str_li", 32'(LoadInstructions), 1);
      chk("str_crst", 32'(cpu_reset), 0);
      chk("str_instr", Instruction, words[i]);
      chk("str_rdy", 32'(byte_ready), 0);
    end

    @(negedge clk); #1;
    chk("rst_cyc_li", 32'(LoadInstructions), 0);
    chk("rst_cyc_crst", 32'(cpu_reset), 1);
    chk("rst_cyc_instr", Instruction, 0);
    chk("rst_cyc_busy", 32'(busy), 1);
    chk("rst_cyc_done", 32'(done), 0);

    @(negedge clk); #1;
    chk("run_done", 32'(done), 1);
    chk("run_busy", 32'(busy), 0);
    chk("run_crst", 32'(cpu_reset), 0);
    chk("run_wl", 32'(words_loaded), n);

    @(negedge clk); #1;
    chk("run_done_clr", 32'(done), 0);
    chk("run_crst2", 32'(cpu_reset), 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    repeat (2) @(negedge clk);
    #1;
    chk("por_crst", 32'(cpu_reset), 1);
    chk("por_li", 32'(LoadInstructions), 0);
    chk("por_instr", Instruction, 0);
    chk("por_rdy", 32'(byte_ready), 0);
    chk("por_busy", 32'(busy), 0);
    chk("por_done", 32'(done), 0);
    chk("por_err", 32'(err), 0);
    chk("por_wl", 32'(words_loaded), 0);
    @(negedge clk); Reset = 1'b1;

    load(3, 0, 1);
    reject(0, 1'b0);
    reject(33, 1'b0);

    src = {8'h12, 8'h34, 8'h56, 8'h78, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
    load(2, 0, -1);
    src = {8'hDE, 8'hAD, 8'hBE, 8'hEF};
    load(1, 1, -1);
    load(32, 2, -1);

    reject(0, 1'b1);
    reject($urandom_range(33, 63), 1'b1);

    repeat (8) load($urandom_range(1, 32), $urandom_range(0, 2), -1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
